// File: rtl/matrix_route_ctrl.sv
// Command-stream front-end for the audio routing matrix: byte commands edit a
// shadow selection bank that is copied to the active bank on a sample tick.
module matrix_route_ctrl #(
  parameter int NOUT = 12,
  parameter int NSRC = 12,
  parameter int SELW = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 sample_tick,
  output logic [NOUT*SELW-1:0] sel_flat,
  output logic                 pending,
  output logic                 commit_done,
  output logic                 err,
  output logic [7:0]           err_count
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ARG       = 2'd1,
    S_WAIT_TICK = 2'd2
  } state_t;

  localparam logic [3:0] OP_SET    = 4'h1;
  localparam logic [3:0] OP_COMMIT = 4'h2;
  localparam logic [3:0] OP_CLEAR  = 4'h3;
  localparam logic [3:0] OP_REVERT = 4'h4;

  state_t                state_q, state_d;
  logic [3:0]            idx_q, idx_d;
  logic [NOUT*SELW-1:0]  shadow_q, shadow_d;
  logic [NOUT*SELW-1:0]  active_q, active_d;
  logic                  pending_q, pending_d;
  logic                  commit_done_q, commit_done_d;
  logic                  err_q, err_d;
  logic [7:0]            err_count_q, err_count_d;

  logic       accept;
  logic [3:0] opcode;
  logic [3:0] arg;
  logic       idx_ok;
  logic       src_ok;

  // Ready depends only on the state register; the bridge may hold a byte
  // across the whole wait for a tick.
  assign in_ready = (state_q != S_WAIT_TICK);
  assign accept   = in_valid && in_ready;
  assign opcode   = in_data[7:4];
  assign arg      = in_data[3:0];
  assign idx_ok   = (idx_q != 4'd0) && (int'(idx_q) <= NOUT);
  assign src_ok   = (int'(arg) <= NSRC);

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    shadow_d      = shadow_q;
    active_d      = active_q;
    commit_done_d = 1'b0;
    err_d         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (opcode)
            OP_SET: begin
              idx_d   = arg;
              state_d = S_ARG;
            end
            OP_COMMIT: state_d  = S_WAIT_TICK;
            OP_CLEAR:  shadow_d = '0;
            OP_REVERT: shadow_d = active_q;
            default:   err_d    = 1'b1;
          endcase
        end
      end
      S_ARG: begin
        if (accept) begin
          state_d = S_IDLE;
          if (idx_ok && src_ok) begin
            for (int k = 0; k < NOUT; k++) begin
              if (int'(idx_q) == k + 1) begin
                shadow_d[k*SELW +: SELW] = SELW'(arg);
              end
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_WAIT_TICK: begin
        // Whole-bank copy in one edge so no sample sees a partial re-patch.
        if (sample_tick) begin
          active_d      = shadow_q;
          commit_done_d = 1'b1;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    pending_d   = (state_d == S_WAIT_TICK);
    err_count_d = (err_d && (err_count_q != 8'hFF)) ? err_count_q + 8'd1 : err_count_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      shadow_q      <= '0;
      active_q      <= '0;
      pending_q     <= 1'b0;
      commit_done_q <= 1'b0;
      err_q         <= 1'b0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      pending_q     <= pending_d;
      commit_done_q <= commit_done_d;
      err_q         <= err_d;
      err_count_q   <= err_count_d;
    end
  end

  assign sel_flat    = active_q;
  assign pending     = pending_q;
  assign commit_done = commit_done_q;
  assign err         = err_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_matrix_route_ctrl.sv
// Scoreboard bench for matrix_route_ctrl: stimulus queues expected commit/err
// events, a negedge monitor pops and compares them as the DUT pulses.
module tb_matrix_route_ctrl;

  localparam int NOUT = 12;
  localparam int NSRC = 12;
  localparam int SELW = 4;
  localparam int W    = NOUT * SELW;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic         sample_tick;
  logic [W-1:0] sel_flat;
  logic         pending;
  logic         commit_done;
  logic         err;
  logic [7:0]   err_count;

  matrix_route_ctrl #(.NOUT(NOUT), .NSRC(NSRC), .SELW(SELW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .sample_tick (sample_tick),
    .sel_flat    (sel_flat),
    .pending     (pending),
    .commit_done (commit_done),
    .err         (err),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           is_commit;
    logic [W-1:0] sel;
    logic [7:0]   cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_commit(input logic [W-1:0] sel);
    exp_t e;
    e.is_commit = 1'b1;
    e.sel       = sel;
    e.cnt       = '0;
    exp_q.push_back(e);
  endtask

  task automatic push_err(input logic [7:0] cnt);
    exp_t e;
    e.is_commit = 1'b0;
    e.sel       = '0;
    e.cnt       = cnt;
    exp_q.push_back(e);
  endtask

  // Monitor: every commit_done / err pulse must match the next queued event.
  always @(negedge clk) begin
    if (!rst && (commit_done || err)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {commit_done, err}, 2'b00);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (commit_done) begin
          chk("event_is_commit", 1'b1, W'(e.is_commit));
          chk("commit_sel_flat", sel_flat, e.sel);
          chk("commit_pending_low", W'(pending), '0);
        end else begin
          chk("event_is_err", 1'b0, W'(e.is_commit));
          chk("err_count", W'(err_count), W'(e.cnt));
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      cyc(1);
      n++;
    end
    if (n >= 200) chk("in_ready_timeout", W'(in_ready), W'(1));
    cyc(1);
    in_valid = 1'b0;
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    cyc(1);
    sample_tick = 1'b0;
  endtask

  task automatic commit_tick(input logic [W-1:0] exp_sel);
    send_byte(8'h20);
    chk("pending_after_commit", W'(pending), W'(1));
    cyc(2);
    push_commit(exp_sel);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    in_data     = '0;
    in_valid    = 1'b0;
    sample_tick = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(1);

    chk("rst_sel_flat", sel_flat, '0);
    chk("rst_pending", W'(pending), '0);
    chk("rst_commit_done", W'(commit_done), '0);
    chk("rst_err", W'(err), '0);
    chk("rst_err_count", W'(err_count), '0);
    chk("rst_in_ready", W'(in_ready), W'(1));

    // Tick while idle must not commit (monitor flags any stray pulse).
    tick();
    cyc(1);

    // SET 3 <- 5, COMMIT, tick ten cycles later.
    send_byte(8'h13);
    send_byte(8'h05);
    send_byte(8'h20);
    chk("t1_pending", W'(pending), W'(1));
    chk("t1_in_ready_low", W'(in_ready), '0);
    cyc(9);
    chk("t1_sel_before_tick", sel_flat, '0);
    push_commit(48'h0000_0000_0500);
    tick();
    chk("t1_commit_done", W'(commit_done), W'(1));
    chk("t1_in_ready_back", W'(in_ready), W'(1));
    cyc(1);
    chk("t1_commit_done_one_cycle", W'(commit_done), '0);

    // SET 1 <- 2, SET 12 <- 12, tick on the COMMIT edge is ignored.
    send_byte(8'h11);
    send_byte(8'h02);
    send_byte(8'h1C);
    send_byte(8'h0C);
    sample_tick = 1'b1;
    send_byte(8'h20);
    sample_tick = 1'b0;
    chk("t2_pending_after_early_tick", W'(pending), W'(1));
    chk("t2_sel_unchanged", sel_flat, 48'h0000_0000_0500);
    cyc(3);
    push_commit(48'hC000_0000_0502);
    tick();

    // Rejected frames and an illegal opcode.
    push_err(8'd1);
    send_byte(8'h10);
    send_byte(8'h0D);
    push_err(8'd2);
    send_byte(8'h1D);
    send_byte(8'h01);
    push_err(8'd3);
    send_byte(8'h10);
    send_byte(8'h01);
    push_err(8'd4);
    send_byte(8'h70);
    cyc(1);
    chk("t3_err_count", W'(err_count), W'(4));
    commit_tick(48'hC000_0000_0502);

    // CLEAR held during WAIT_TICK is only taken after the commit.
    send_byte(8'h20);
    in_data  = 8'h30;
    in_valid = 1'b1;
    cyc(20);
    chk("t4_in_ready_low", W'(in_ready), '0);
    chk("t4_pending_held", W'(pending), W'(1));
    push_commit(48'hC000_0000_0502);
    tick();
    chk("t4_in_ready_high", W'(in_ready), W'(1));
    cyc(1);
    in_valid = 1'b0;
    commit_tick('0);

    // REVERT discards an uncommitted edit of output 4.
    send_byte(8'h14);
    send_byte(8'h03);
    commit_tick(48'h0000_0000_3000);
    send_byte(8'h14);
    send_byte(8'h07);
    send_byte(8'h40);
    commit_tick(48'h0000_0000_3000);

    // Reset mid-frame.
    send_byte(8'h15);
    rst = 1'b1;
    #2;
    chk("t6_rst_sel", sel_flat, '0);
    chk("t6_rst_pending", W'(pending), '0);
    chk("t6_rst_err_count", W'(err_count), '0);
    cyc(1);
    rst = 1'b0;
    cyc(1);
    push_err(8'd1);
    send_byte(8'h09);
    cyc(1);

    // Reset while a commit is pending.
    send_byte(8'h12);
    send_byte(8'h01);
    send_byte(8'h20);
    chk("t6_pending_before_rst", W'(pending), W'(1));
    rst = 1'b1;
    #2;
    chk("t6_rst2_pending", W'(pending), '0);
    chk("t6_rst2_sel", sel_flat, '0);
    chk("t6_rst2_err_count", W'(err_count), '0);
    cyc(1);
    rst = 1'b0;
    cyc(1);
    chk("t6_in_ready_after_rst", W'(in_ready), W'(1));
    tick();
    cyc(1);
    chk("t6_no_commit_after_rst", sel_flat, '0);

    // err_count saturates at 255 while err keeps pulsing.
    for (int i = 1; i <= 258; i++) begin
      push_err((i > 255) ? 8'd255 : 8'(i));
      send_byte(8'hF0);
    end
    cyc(2);
    chk("sat_err_count", W'(err_count), W'(255));

    cyc(3);
    chk("scoreboard_drained", W'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
